// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encodings, port ids and the
// funct3 access-size codes understood by data_memory.
package dmem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module dmem_arbiter_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       winner_o,
    output logic       valid_o
);

    // Winner selection from the request pair and the previous winner
    always_comb begin
        winner_o = 1'b0;
        valid_o  = |req_i;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~rr_last_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the CPU path (port 0) and the
// loader/debug path (port 1); one transaction at a time, with an abort watchdog.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [2:0]        size0_i,
    input  logic [2:0]        size1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              owner_q, owner_d;
    logic              first_q, first_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic winner_s;
    logic any_req_s;

    dmem_arbiter_rr_arb2 u_rr_arb2 (
        .req_i     (req_i),
        .rr_last_i (rr_last_q),
        .winner_o  (winner_s),
        .valid_o   (any_req_s)
    );

    // Next-state logic for the FSM, transaction register and watchdog
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        first_d   = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wdog_d    = wdog_q;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (any_req_s) begin
                    state_d   = ST_ACCESS;
                    owner_d   = winner_s;
                    rr_last_d = winner_s;
                    first_d   = 1'b1;
                    wdog_d    = '0;
                    we_d      = winner_s ? we_i[1]  : we_i[0];
                    addr_d    = winner_s ? addr1_i  : addr0_i;
                    wdata_d   = winner_s ? wdata1_i : wdata0_i;
                    size_d    = winner_s ? size1_i  : size0_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ready_i) begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? '0 : mem_rdata_i;
                    err_d   = 1'b0;
                end else if (wdog_q >= WD_LAST) begin
                    // the count reaches TIMEOUT this cycle with no ready: abort
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    wdog_d  = WD_MAX;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            first_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= 3'b000;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            first_q   <= first_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wdog_q    <= wdog_d;
        end
    end

    logic in_access_s;
    logic in_resp_s;
    assign in_access_s = (state_q == ST_ACCESS);
    assign in_resp_s   = (state_q == ST_RESP);

    assign gnt_o        = (in_access_s && first_q) ? port_onehot(owner_q) : 2'b00;
    assign mem_read_o   = in_access_s && !we_q;
    assign mem_write_o  = in_access_s && we_q;
    assign mem_addr_o   = in_access_s ? addr_q  : '0;
    assign mem_wdata_o  = in_access_s ? wdata_q : '0;
    assign mem_funct3_o = in_access_s ? size_q  : 3'b000;
    assign rvalid_o     = in_resp_s ? port_onehot(owner_q) : 2'b00;
    assign rdata_o      = in_resp_s ? rdata_q : '0;
    assign err_o        = in_resp_s && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, load, contention, store, timeout,
// late-ready boundary and reset during an access.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, gnt, rvalid;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  size0, size1, mem_funct3;
    logic        err, mem_read, mem_write, mem_ready;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .size0_i(size0), .size1_i(size1), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_funct3_o(mem_funct3),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // protocol invariants on the opposite edge
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            total++;
            assert ($onehot0(gnt) && $onehot0(rvalid) && !(mem_read && mem_write)) else begin
                bad++;
                $error("FAIL onehot observed=gnt%b/rv%b/rd%b/wr%b expected=onehot0,no-both",
                       gnt, rvalid, mem_read, mem_write);
            end
        end
    end

    initial begin
        rst = 1'b0; req = 2'b11; we = 2'b00;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        size0 = F3_LW; size1 = F3_LW;
        mem_rdata = 32'hDEADBEEF; mem_ready = 1'b0;

        // 1: reset held with both requests pending
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", {30'd0, gnt}, 32'd0);
            chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
            chk("rst_rd", {31'd0, mem_read}, 32'd0);
            chk("rst_wr", {31'd0, mem_write}, 32'd0);
        end
        rst = 1'b1; req = 2'b00;
        tick();

        // 2: single load from port 0
        req = 2'b01; we = 2'b00; addr0 = 32'h10; mem_ready = 1'b1;
        tick();
        chk("ld_gnt", {30'd0, gnt}, 32'd1);
        chk("ld_rd", {31'd0, mem_read}, 32'd1);
        chk("ld_addr", mem_addr, 32'h10);
        req = 2'b00;
        tick();
        chk("ld_rvalid", {30'd0, rvalid}, 32'd1);
        chk("ld_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk("ld_idle_rdata", rdata, 32'd0);

        // 3: contention after a fresh reset, grants must alternate from port 0
        rst = 1'b0; tick(); rst = 1'b1;
        req = 2'b11; addr1 = 32'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", {30'd0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_rvalid", {30'd0, rvalid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        req = 2'b00;
        tick();

        // 4: store from port 1
        req = 2'b10; we = 2'b10; addr1 = 32'h24; wdata1 = 32'h55AA; size1 = F3_SW;
        tick();
        chk("st_gnt", {30'd0, gnt}, 32'd2);
        chk("st_wr", {31'd0, mem_write}, 32'd1);
        chk("st_rd", {31'd0, mem_read}, 32'd0);
        chk("st_addr", mem_addr, 32'h24);
        chk("st_wdata", mem_wdata, 32'h55AA);
        chk("st_f3", {29'd0, mem_funct3}, 32'd2);
        req = 2'b00;
        tick();
        chk("st_rvalid", {30'd0, rvalid}, 32'd2);
        chk("st_rdata", rdata, 32'd0);
        chk("st_err", {31'd0, err}, 32'd0);
        tick();

        // 5: timeout with mem_ready stuck low
        req = 2'b01; we = 2'b00; addr0 = 32'h40; mem_ready = 1'b0;
        tick();
        req = 2'b00;
        for (int c = 1; c <= 15; c++) begin
            chk("to_rd_held", {31'd0, mem_read}, 32'd1);
            tick();
        end
        chk("to_rd_drop", {31'd0, mem_read}, 32'd0);
        chk("to_rvalid", {30'd0, rvalid}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rdata", rdata, 32'd0);
        tick();
        chk("to_err_clr", {31'd0, err}, 32'd0);
        mem_ready = 1'b1; req = 2'b01;
        tick();
        chk("post_to_gnt", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        tick();
        chk("post_to_rdata", rdata, 32'hDEADBEEF);
        chk("post_to_err", {31'd0, err}, 32'd0);
        tick();

        // ready in the 15th access cycle still counts as success
        req = 2'b01; mem_ready = 1'b0;
        tick();
        req = 2'b00;
        for (int c = 1; c < 15; c++) tick();
        chk("late_rd", {31'd0, mem_read}, 32'd1);
        mem_ready = 1'b1;
        tick();
        chk("late_rvalid", {30'd0, rvalid}, 32'd1);
        chk("late_err", {31'd0, err}, 32'd0);
        chk("late_rdata", rdata, 32'hDEADBEEF);
        tick();

        // 6: reset in the second access cycle
        req = 2'b10; we = 2'b00; mem_ready = 1'b0;
        tick();
        chk("mr_rd1", {31'd0, mem_read}, 32'd1);
        tick();
        chk("mr_rd2", {31'd0, mem_read}, 32'd1);
        rst = 1'b0;
        tick();
        chk("mr_rd_drop", {31'd0, mem_read}, 32'd0);
        chk("mr_rvalid", {30'd0, rvalid}, 32'd0);
        rst = 1'b1; req = 2'b11; mem_ready = 1'b1;
        tick();
        chk("mr_tie_gnt", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        tick();
        chk("mr_rvalid_after", {30'd0, rvalid}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
